icache_direct_mapped: RTL and testbench



---
 rtl/icache_direct_mapped.sv | 133 +++++++++++++
 tb/tb_icache_direct_mapped.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_direct_mapped.sv
// Direct-mapped instruction cache with zero-cycle hits and a block refill FSM.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_direct_mapped #(
    parameter int ADDR_BITS  = 10,
    parameter int INDEX_BITS = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [31:0]           PC,
    input  logic                  READ,
    output logic [31:0]           INSTRUCTION,
    output logic                  BUSYWAIT,
    output logic                  MEM_READ,
    output logic [ADDR_BITS-5:0]  MEM_ADDRESS,
    input  logic [127:0]          MEM_READDATA,
    input  logic                  MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]           HIT_COUNT,
    output logic [15:0]           MISS_COUNT
`endif
);

    localparam int TAG_BITS = ADDR_BITS - 4 - INDEX_BITS;
    localparam int BLOCKS   = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEM_READ,
        ST_UPDATE
    } state_t;

    state_t                       state;
    logic [BLOCKS-1:0]            valid;
    logic [TAG_BITS-1:0]          tag_arr  [BLOCKS];
    logic [127:0]                 data_arr [BLOCKS];
    logic [127:0]                 fill;
    logic [ADDR_BITS-5:0]         miss_addr;
    logic                         mem_read_q;

    logic [INDEX_BITS-1:0]        pc_index;
    logic [TAG_BITS-1:0]          pc_tag;
    logic [1:0]                   pc_word;
    logic [INDEX_BITS-1:0]        miss_index;
    logic [TAG_BITS-1:0]          miss_tag;
    logic [127:0]                 line;
    logic                         hit;
    logic                         unused_pc;

    assign pc_word    = PC[3:2];
    assign pc_index   = PC[INDEX_BITS+3:4];
    assign pc_tag     = PC[ADDR_BITS-1:INDEX_BITS+4];
    assign unused_pc  = ^{PC[31:ADDR_BITS], PC[1:0]};
    assign miss_index = miss_addr[INDEX_BITS-1:0];
    assign miss_tag   = miss_addr[ADDR_BITS-5:INDEX_BITS];

    assign line = data_arr[pc_index];
    assign hit  = READ & valid[pc_index] & (tag_arr[pc_index] == pc_tag);

    always_comb begin
        INSTRUCTION = 32'h0;
        if (hit) begin
            INSTRUCTION = line[{pc_word, 5'b0} +: 32];
        end
    end

    // Stall covers the detect cycle plus every refill cycle
    assign BUSYWAIT    = (state != ST_IDLE) | (READ & ~hit);
    assign MEM_READ    = mem_read_q;
    assign MEM_ADDRESS = miss_addr;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ST_IDLE;
            valid      <= '0;
            miss_addr  <= '0;
            mem_read_q <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (READ && !hit) begin
                        miss_addr  <= {pc_tag, pc_index};
                        mem_read_q <= 1'b1;
                        state      <= ST_MEM_READ;
                    end
                end
                ST_MEM_READ: begin
                    if (!MEM_BUSYWAIT) begin
                        mem_read_q <= 1'b0;
                        state      <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    valid[miss_index] <= 1'b1;
                    state             <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Tag and data storage carry no reset; only the valid bits do
    always_ff @(posedge CLK) begin
        if (state == ST_MEM_READ && !MEM_BUSYWAIT) begin
            fill <= MEM_READDATA;
        end
        if (state == ST_UPDATE && !RESET) begin
            data_arr[miss_index] <= fill;
            tag_arr[miss_index]  <= miss_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic prev_update;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            HIT_COUNT   <= '0;
            MISS_COUNT  <= '0;
            prev_update <= 1'b0;
        end else begin
            prev_update <= (state == ST_UPDATE);
            if (state == ST_IDLE && READ && !hit && MISS_COUNT != 16'hFFFF) begin
                MISS_COUNT <= MISS_COUNT + 16'd1;
            end
            if (state == ST_IDLE && hit && !prev_update && HIT_COUNT != 16'hFFFF) begin
                HIT_COUNT <= HIT_COUNT + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Randomized self-checking bench for icache_direct_mapped against a
// transaction-level cache model and a variable-latency memory model.
module tb_icache_direct_mapped;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [31:0]  PC;
    logic         READ;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;
`ifdef ICACHE_STATS_EN
    logic [15:0]  HIT_COUNT;
    logic [15:0]  MISS_COUNT;
`endif

    icache_direct_mapped dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PC           (PC),
        .READ         (READ),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
        ,
        .HIT_COUNT    (HIT_COUNT),
        .MISS_COUNT   (MISS_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Instruction memory: 64 blocks x 4 words, word-addressed
    logic [31:0] mem_w [256];
    int          lat = 5;
    int          mcnt = 0;

    always_comb begin
        MEM_READDATA = '0;
        for (int w = 0; w < 4; w++) begin
            MEM_READDATA[w*32 +: 32] = mem_w[int'(MEM_ADDRESS) * 4 + w];
        end
    end

    assign MEM_BUSYWAIT = MEM_READ && (mcnt < lat - 1);

    always @(posedge CLK) begin
        if (MEM_READ) mcnt <= mcnt + 1;
        else mcnt <= 0;
    end

    // Reference model state
    bit m_valid [8];
    int m_tag   [8];
    int m_hits  = 0;
    int m_miss  = 0;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_valid[i] = 0;
        m_hits = 0;
        m_miss = 0;
    endfunction

    task automatic fetch(input logic [31:0] pc, input int latency);
        int a, idx, tg, cycles, mrc;
        a   = int'(pc % 1024);
        idx = (a / 16) % 8;
        tg  = a / 128;
        lat = latency;
        PC  = pc;
        READ = 1'b1;
        @(negedge CLK);
        if (m_valid[idx] && m_tag[idx] == tg) begin
            m_hits++;
            chk("hit_busy", {31'b0, BUSYWAIT}, 32'h0);
            chk("hit_memrd", {31'b0, MEM_READ}, 32'h0);
            chk("hit_instr", INSTRUCTION, mem_w[a / 4]);
        end else begin
            m_miss++;
            cycles = 0;
            mrc = 0;
            while (BUSYWAIT === 1'b1 && cycles < 200) begin
                if (MEM_READ === 1'b1) begin
                    mrc++;
                    if (mrc == 1)
                        chk("miss_addr", {26'b0, MEM_ADDRESS}, a / 16);
                end
                cycles++;
                @(negedge CLK);
            end
            chk("miss_busy_cyc", cycles, latency + 2);
            chk("miss_mr_cyc", mrc, latency);
            chk("miss_instr", INSTRUCTION, mem_w[a / 4]);
            m_valid[idx] = 1;
            m_tag[idx]   = tg;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        READ  = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_reset();
    endtask

    task automatic chk_stats(input string tag);
`ifdef ICACHE_STATS_EN
        chk({tag, "_hits"}, {16'b0, HIT_COUNT}, m_hits);
        chk({tag, "_miss"}, {16'b0, MISS_COUNT}, m_miss);
`else
        chk({tag, "_idle"}, {31'b0, BUSYWAIT}, 32'h0);
`endif
    endtask

    initial begin
        int cycles, mrc, first_a, last_a, seen;
        for (int i = 0; i < 256; i++) mem_w[i] = $urandom;
        mem_w[0] = 32'h1;
        mem_w[1] = 32'h4;
        mem_w[2] = 32'h8;
        mem_w[3] = 32'hC;
        PC    = 32'hFFFF_FFFC;
        READ  = 1'b0;
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        do_reset();

        @(negedge CLK);
        chk("rst_busy", {31'b0, BUSYWAIT}, 32'h0);
        chk("rst_instr", INSTRUCTION, 32'h0);
        chk("rst_memrd", {31'b0, MEM_READ}, 32'h0);
        chk("rst_maddr", {26'b0, MEM_ADDRESS}, 32'h0);
        chk_stats("rst");
        @(posedge CLK);
        #1;

        fetch(32'd0, 5);
        fetch(32'd4, 3);
        fetch(32'd8, 3);
        fetch(32'd16, 4);
        chk_stats("plan");
        fetch(32'd12, 3);
        fetch(32'd128, 3);
        fetch(32'd0, 2);
        fetch(32'hFFFF_FC04, 2);

        // Reset in the third refill cycle must discard the fill
        PC   = 32'(((m_valid[0] ? m_tag[0] : 0) + 1) % 8 * 128);
        READ = 1'b1;
        lat  = 6;
        cycles = 0;
        mrc = 0;
        @(negedge CLK);
        while (mrc < 3 && cycles < 50) begin
            if (MEM_READ === 1'b1) mrc++;
            cycles++;
            if (mrc < 3) @(negedge CLK);
        end
        chk("rst_mid_reach", mrc, 3);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        READ  = 1'b0;
        model_reset();
        @(negedge CLK);
        chk("rst_mid_memrd", {31'b0, MEM_READ}, 32'h0);
        chk("rst_mid_busy", {31'b0, BUSYWAIT}, 32'h0);
        chk("rst_mid_instr", INSTRUCTION, 32'h0);
        @(posedge CLK);
        #1;
        fetch(32'd0, 3);

        // PC moves to block 1 during the block 0 refill
        do_reset();
        lat  = 4;
        PC   = 32'd0;
        READ = 1'b1;
        cycles = 0;
        seen = 0;
        first_a = -1;
        last_a = -1;
        @(negedge CLK);
        while (BUSYWAIT === 1'b1 && cycles < 200) begin
            if (MEM_READ === 1'b1) begin
                if (seen == 0) first_a = int'(MEM_ADDRESS);
                seen = 1;
                last_a = int'(MEM_ADDRESS);
            end
            cycles++;
            if (cycles == 3) PC = 32'd16;
            @(negedge CLK);
        end
        chk("pcchg_cyc", cycles, 12);
        chk("pcchg_first", first_a, 0);
        chk("pcchg_last", last_a, 1);
        chk("pcchg_instr", INSTRUCTION, mem_w[4]);
        m_valid[0] = 1;
        m_tag[0]   = 0;
        m_valid[1] = 1;
        m_tag[1]   = 0;
        m_miss += 2;
        @(posedge CLK);
        #1;
        fetch(32'd4, 2);
        fetch(32'd20, 2);
        chk_stats("pcchg");

        // Random fetches over a small footprint to mix hits and conflicts
        for (int n = 0; n < 60; n++) begin
            logic [31:0] rpc;
            rpc = {$urandom_range(0, 3) == 0 ? 22'($urandom) : 22'd0,
                   1'b0, 3'($urandom_range(0, 1) * 7), 2'($urandom),
                   2'($urandom), 2'b00};
            fetch(rpc, $urandom_range(2, 6));
        end
        READ = 1'b0;
        @(negedge CLK);
        chk_stats("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
